pow2_approx: RTL
================

# pow2_approx

Pipelined base-2 antilog unit for the softmax datapath. It sits directly downstream of `constant_multipler`: it consumes the scaled value x·log2(e) and produces 2^x using Mitchell's approximation, 2^(k+f) ≈ (1+f)·2^k. It uses a valid/ready handshake, and an optional per-row accumulator produces the softmax denominator.

## Interface
Parameters:
- IN_W, 32: input width, two's complement.
- IN_FRAC, 8: input fraction bits.
- OUT_W, `OUTPUT_BUF_DATASIZE (32): output width, unsigned.
- OUT_FRAC, 16: output fraction bits.
- SUM_W, 40: accumulator width. Present only with the macro.

Ports:
- clk in 1: clock. Rising edge.
- rst in 1: reset. Asynchronous assert, active-low.
- in_data in IN_W: x·log2(e) in signed Q(IN_W−IN_FRAC).IN_FRAC.
- in_last in 1: marks the last element of a row.
- in_valid in 1: input valid.
- in_ready out 1: input ready.
- out_data out OUT_W: 2^x in unsigned Q.OUT_FRAC.
- out_sat out 1: result was saturated high.
- out_last out 1: in_last delayed with its data.
- out_valid out 1: output valid.
- out_ready in 1: output ready.
- sum_out out SUM_W: row sum. Present only with the macro.
- sum_count out 16: elements in the row. Present only with the macro.
- sum_valid out 1: one-cycle row-sum pulse. Present only with the macro.

## Operation
- Split the input:
  - k = in_data >>> IN_FRAC (arithmetic shift, i.e. floor).
  - f = in_data[IN_FRAC−1:0].
  - mantissa m = {1'b1, f}, width IN_FRAC+1.
- Shift amount: s = k + OUT_FRAC − IN_FRAC.
  - If s ≥ 0, result = m << s.
  - Otherwise, result = m >> (−s).
- Classification, where the top bit of m lands at position IN_FRAC + s:
  - If IN_FRAC + s > OUT_W−1: out_data = all ones, out_sat = 1.
  - If −s > IN_FRAC: out_data = 0, out_sat = 0.
  - Otherwise: normal shift, truncated (no rounding).
- Pipeline stages:
  - S1: register k, f and last.
  - S2: register s and the class (normal / saturate / zero).
  - S3: barrel shift and register the result to the outputs.
- Stall rule: adv = !out_valid || out_ready.
  - All stages, including their valid bits, load only when adv = 1.
  - in_ready = adv (combinational from out_ready). Acceptance is in_valid && in_ready.
- Bubbles propagate as valid = 0. They are not compressed.
- No FSM in the datapath. The sum block is a two-state machine:
  - IDLE → ACC on the first output transfer of a row.
  - ACC → IDLE on a transfer carrying out_last.

## Timing
- Latency is 3 cycles from acceptance to out_valid when out_ready = 1 throughout. Throughput is 1 per cycle.
- Reset values: out_data = 0, out_sat = 0, out_last = 0, out_valid = 0, all stage valids = 0, sum_out = 0, sum_count = 0, sum_valid = 0, state = IDLE.
- Output stability: while out_valid && !out_ready, out_data, out_sat and out_last hold steady and no input is accepted.
- Reset mid-operation: in-flight elements and any partial sum are discarded with no output. After release, the first accepted element starts a new row.
- Sum behaviour:
  - On every output transfer, acc += out_data (zero-extended) and the count increments.
  - acc saturates at 2^SUM_W−1. sum_count wraps at 16 bits.
  - On the transfer with out_last = 1, sum_out and sum_count update to include that element and sum_valid is high for exactly 1 cycle, the next one. The accumulator clears in the same cycle.
  - If the first element of the next row transfers in that same cycle, it goes into the cleared accumulator and is not lost.
  - A row of one element (in_last on its only element) is legal: sum_count = 1.

## Configuration
- Macro `SOFTMAX_SUM_EN`.
- When defined: sum_out, sum_count, sum_valid, SUM_W and the accumulator/FSM are present.
- When undefined: those ports and the logic are absent. out_last is still produced, and the datapath is cycle-identical.

## Structure
- Shared constants go in `config.v`: `OUTPUT_BUF_DATASIZE, `POW2_IN_FRAC (8), `POW2_OUT_FRAC (16) and the class encoding (NORMAL = 2'd0, SAT = 2'd1, ZERO = 2'd2).
- One sub-module, `pow2_shifter`: the combinational S3 barrel shift. Inputs are m, s and class; output is the OUT_W result.
- The top level holds the pipeline registers, handshake and sum block.

## Test plan
All values use defaults (Q.8 in, Q.16 out).
- Basic values, out_ready = 1:
  - 0x00000000 → 3 cycles later out_data = 0x00010000, out_sat = 0.
  - 0x00000080 (0.5) → 0x00018000.
  - 0xFFFFFF00 (−1.0) → 0x00008000.
- Boundaries:
  - 0x00000F00 (15.0) → 0x80000000.
  - 0x00001000 (16.0) → 0xFFFFFFFF with out_sat = 1.
  - 0xFFFFE800 (−24.0) → 0x00000000, out_sat = 0.
- Back-pressure: stream 6 values with out_ready low on cycles 4–7. Required: no loss or duplication, order preserved, in_ready low during the stall, and out_data stable while held.
- Row sum (macro defined): 0x0, 0x0, 0xFFFFFF00 with in_last on the third. Required: sum_valid pulses once with sum_out = 0x000028000 and sum_count = 3. The next row starts from 0.
- Back-to-back rows: a single-element row (last = 1, value 0x0) immediately followed by a row of 2 × 0x0. Required: sums 0x10000/count 1, then 0x20000/count 2.
- Reset mid-stream: assert rst with 2 elements in flight and 1 summed. Required: all outputs 0 immediately, with no out_valid or sum_valid until new input arrives.

Source files
------------

// File: rtl/pow2_approx_pkg.sv
// Shared constants and encodings for the pow2_approx antilog pipeline.
// Default widths live here so the pipeline and its shifter agree on them.
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif
`ifndef POW2_IN_FRAC
`define POW2_IN_FRAC 8
`endif
`ifndef POW2_OUT_FRAC
`define POW2_OUT_FRAC 16
`endif

package pow2_approx_pkg;
  localparam int POW2_IN_FRAC  = `POW2_IN_FRAC;
  localparam int POW2_OUT_FRAC = `POW2_OUT_FRAC;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_SAT    = 2'd1,
    CLS_ZERO   = 2'd2
  } cls_e;

  typedef enum logic {
    SUM_IDLE = 1'b0,
    SUM_ACC  = 1'b1
  } sum_state_e;
endpackage

// File: rtl/pow2_shifter.sv
// Combinational S3 barrel shift: places mantissa {1,f} at 2^s, or forces the
// saturate/zero result chosen upstream.
module pow2_shifter
  import pow2_approx_pkg::*;
#(
  parameter int IN_FRAC = 8,
  parameter int OUT_W   = 32,
  parameter int SH_W    = 7
) (
  input  logic [IN_FRAC:0]  m,
  input  logic [SH_W-1:0]   s,
  input  logic [1:0]        cls,
  output logic [OUT_W-1:0]  res
);
  logic [OUT_W-1:0] mw;
  logic [SH_W-1:0]  mag;

  assign mw  = OUT_W'(m);
  // s is two's complement; only its magnitude drives the shifter
  assign mag = s[SH_W-1] ? (~s + SH_W'(1)) : s;

  always_comb begin
    res = '0;
    case (cls)
      CLS_SAT:    res = '1;
      CLS_NORMAL: res = s[SH_W-1] ? (mw >> mag) : (mw << mag);
      default:    res = '0;
    endcase
  end
endmodule

// File: rtl/pow2_approx.sv
// Three-stage Mitchell antilog 2^x with valid/ready stall; optional per-row
// softmax denominator accumulator enabled by `SOFTMAX_SUM_EN.
module pow2_approx
  import pow2_approx_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int IN_FRAC  = POW2_IN_FRAC,
  parameter int OUT_W    = `OUTPUT_BUF_DATASIZE,
  parameter int OUT_FRAC = POW2_OUT_FRAC
`ifdef SOFTMAX_SUM_EN
  ,
  parameter int SUM_W    = 40
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SOFTMAX_SUM_EN
  ,
  output logic [SUM_W-1:0] sum_out,
  output logic [15:0]      sum_count,
  output logic             sum_valid
`endif
);
  localparam int STAGES = 3;
  localparam int KW     = IN_W - IN_FRAC;
  localparam int SW     = KW + 2;
  localparam int SH_W   = $clog2(OUT_W + IN_FRAC) + 1;
  localparam logic signed [SW-1:0] SAT_TH  = SW'(OUT_W - 1 - IN_FRAC);
  localparam logic signed [SW-1:0] ZERO_TH = SW'(-IN_FRAC);

  logic [STAGES-1:0] vld_pipe;
  logic              adv;

  // S1
  logic [KW-1:0]      k1;
  logic [IN_FRAC-1:0] f1;
  logic               last1;
  // S2
  logic signed [SW-1:0] s_full;
  logic [1:0]           cls1;
  logic [IN_FRAC:0]     m2;
  logic [SH_W-1:0]      s2;
  logic [1:0]           cls2;
  logic                 last2;
  // S3
  logic [OUT_W-1:0]     shift_res;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES-1];

  // The upper bits of in_data are already floor(x) in two's complement
  always_comb begin
    s_full = {{2{k1[KW-1]}}, k1} + SW'(OUT_FRAC - IN_FRAC);
    cls1   = CLS_NORMAL;
    if (s_full > SAT_TH)       cls1 = CLS_SAT;
    else if (s_full < ZERO_TH) cls1 = CLS_ZERO;
  end

  pow2_shifter #(
    .IN_FRAC (IN_FRAC),
    .OUT_W   (OUT_W),
    .SH_W    (SH_W)
  ) u_shift (
    .m   (m2),
    .s   (s2),
    .cls (cls2),
    .res (shift_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      k1       <= '0;
      f1       <= '0;
      last1    <= 1'b0;
      m2       <= '0;
      s2       <= '0;
      cls2     <= CLS_ZERO;
      last2    <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
      out_last <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
      k1       <= in_data[IN_W-1:IN_FRAC];
      f1       <= in_data[IN_FRAC-1:0];
      last1    <= in_last && in_valid;
      m2       <= {1'b1, f1};
      s2       <= s_full[SH_W-1:0];
      cls2     <= cls1;
      last2    <= last1 && vld_pipe[0];
      out_data <= shift_res;
      out_sat  <= (cls2 == CLS_SAT);
      out_last <= last2 && vld_pipe[1];
    end
  end

`ifdef SOFTMAX_SUM_EN
  sum_state_e       state, state_nx;
  logic             xfer;
  logic [SUM_W-1:0] acc, acc_base, acc_nx;
  logic [15:0]      cnt, cnt_base, cnt_nx;
  logic [SUM_W:0]   acc_sum;

  assign xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SUM_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SUM_IDLE: if (xfer && !out_last) state_nx = SUM_ACC;
      SUM_ACC:  if (xfer && out_last)  state_nx = SUM_IDLE;
      default:  state_nx = SUM_IDLE;
    endcase
  end

  // A row always starts from zero, whatever the accumulator still holds
  always_comb begin
    acc_base = (state == SUM_IDLE) ? '0 : acc;
    cnt_base = (state == SUM_IDLE) ? '0 : cnt;
    acc_sum  = {1'b0, acc_base} + {{(SUM_W + 1 - OUT_W){1'b0}}, out_data};
    acc_nx   = acc_sum[SUM_W] ? '1 : acc_sum[SUM_W-1:0];
    cnt_nx   = cnt_base + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      sum_out   <= '0;
      sum_count <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (xfer) begin
        if (out_last) begin
          sum_out   <= acc_nx;
          sum_count <= cnt_nx;
          sum_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc_nx;
          cnt <= cnt_nx;
        end
      end
    end
  end
`endif
endmodule
